// File: rtl/uart_pkg.sv
// Shared types for the UART transmit FIFO: the byte type and the
// transmit-launch state machine encoding.
package uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: synchronous write port, combinational read of the
// addressed (head) entry. Contents are deliberately not reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   byte_t mem_q [DEPTH];

   // Store the incoming byte at the write address on an accepted write.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= byte_t'(wdata_i);
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. Bytes written on WR_i are queued and
// handed to the UART one at a time with a single-cycle TX_START_o pulse; a
// watchdog recovers if the UART never raises TX_BUSY_i.
// Optional build macro: UART_TX_FIFO_OVF_EN enables the sticky overflow flag
// (OVF_o); without it OVF_o is tied low and OVF_CLR_i is ignored.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int BUSY_WAIT = 4
) (
   input  logic                     CLK_i,
   input  logic                     RSTn_i,
   input  logic                     WR_i,
   input  logic [7:0]               WDATA_i,
   output logic                     FULL_o,
   output logic                     EMPTY_o,
   output logic [$clog2(DEPTH):0]   COUNT_o,
   input  logic                     TX_BUSY_i,
   output logic                     TX_START_o,
   output logic [7:0]               TX_BYTE_o,
   input  logic                     OVF_CLR_i,
   output logic                     OVF_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int WDW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(BUSY_WAIT - 1);

   // Pointers carry one extra bit so that equal low bits can be told apart
   // as either empty (MSBs equal) or full (MSBs differ).
   logic [AW:0]    wptr_q, wptr_d;
   logic [AW:0]    rptr_q, rptr_d;
   logic           full, empty;
   logic           wr_acc, pop;
   logic [7:0]     head;

   tx_state_e      state_q;
   logic           tx_start_q;
   byte_t          tx_byte_q;
   logic [WDW-1:0] wd_q;

   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // A write on a full FIFO is dropped even if a pop happens on the same edge.
   assign wr_acc = WR_i && !full;
   assign pop    = (state_q == ST_IDLE) && !empty && !TX_BUSY_i;

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (CLK_i),
      .we_i    (wr_acc),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (WDATA_i),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (head)
   );

   // Next pointer values: advance on accepted write / on pop.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_acc) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
   end

   // Pointer registers; reset discards all queued bytes.
   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Transmit launch FSM with registered start pulse, byte and watchdog.
   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         state_q    <= ST_IDLE;
         tx_start_q <= 1'b0;
         tx_byte_q  <= '0;
         wd_q       <= '0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  tx_byte_q  <= byte_t'(head);
                  tx_start_q <= 1'b1;
                  state_q    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               wd_q    <= '0;
               state_q <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (TX_BUSY_i) begin
                  state_q <= ST_WAIT_DONE;
               end else if (wd_q == WD_LAST) begin
                  // UART never acknowledged; treat the byte as sent.
                  state_q <= ST_IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!TX_BUSY_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign FULL_o     = full;
   assign EMPTY_o    = empty;
   assign COUNT_o    = wptr_q - rptr_q;
   assign TX_START_o = tx_start_q;
   assign TX_BYTE_o  = tx_byte_q;

`ifdef UART_TX_FIFO_OVF_EN
   logic ovf_q;

   // Sticky overflow: any dropped write sets it, clear request clears it,
   // and a simultaneous drop wins over the clear.
   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         ovf_q <= 1'b0;
      end else if (WR_i && full) begin
         ovf_q <= 1'b1;
      end else if (OVF_CLR_i) begin
         ovf_q <= 1'b0;
      end
   end

   assign OVF_o = ovf_q;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = OVF_CLR_i;
   assign OVF_o          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a scoreboard queue holds the bytes
// expected on the UART side, popped by a monitor on every TX_START_o pulse.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

`ifdef UART_TX_FIFO_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic       CLK_i;
   logic       RSTn_i;
   logic       WR_i;
   logic [7:0] WDATA_i;
   logic       FULL_o;
   logic       EMPTY_o;
   logic [4:0] COUNT_o;
   logic       TX_BUSY_i;
   logic       TX_START_o;
   logic [7:0] TX_BYTE_o;
   logic       OVF_CLR_i;
   logic       OVF_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pulse_cnt = 0;
   int last_pulse_cyc = 0;

   logic [7:0] exp_q [$];

   logic force_busy;
   logic model_en;
   int   busy_len;
   int   busy_cnt;
   logic prev_start;

   uart_tx_fifo #(
      .DEPTH     (DEPTH),
      .BUSY_WAIT (4)
   ) dut (
      .CLK_i      (CLK_i),
      .RSTn_i     (RSTn_i),
      .WR_i       (WR_i),
      .WDATA_i    (WDATA_i),
      .FULL_o     (FULL_o),
      .EMPTY_o    (EMPTY_o),
      .COUNT_o    (COUNT_o),
      .TX_BUSY_i  (TX_BUSY_i),
      .TX_START_o (TX_START_o),
      .TX_BYTE_o  (TX_BYTE_o),
      .OVF_CLR_i  (OVF_CLR_i),
      .OVF_o      (OVF_o)
   );

   initial CLK_i = 1'b0;
   always #5 CLK_i = ~CLK_i;

   always @(posedge CLK_i) cyc <= cyc + 1;

   // Simple UART model: busy for busy_len cycles after seeing a start pulse.
   always @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) busy_cnt <= 0;
      else if (model_en && TX_START_o) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   assign TX_BUSY_i = force_busy | (busy_cnt != 0);

   // Monitor: every start pulse must carry the next expected byte.
   always @(negedge CLK_i) begin
      if (RSTn_i === 1'b1 && TX_START_o === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         last_pulse_cyc = cyc;
         n_checks++;
         if (TX_BUSY_i !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy: busy=%b required 0", TX_BUSY_i);
         end
         n_checks++;
         if (prev_start === 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_start: previous cycle start=%b required 0", prev_start);
         end
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: byte=%02h sent, none expected", TX_BYTE_o);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (TX_BYTE_o !== e) begin
               n_fail++;
               $display("FAIL tx_byte: got %02h required %02h", TX_BYTE_o, e);
            end
         end
      end
      prev_start = TX_START_o;
   end

   task automatic apply_reset();
      @(negedge CLK_i);
      RSTn_i     = 1'b0;
      WR_i       = 1'b0;
      OVF_CLR_i  = 1'b0;
      force_busy = 1'b0;
      model_en   = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge CLK_i);
      RSTn_i = 1'b1;
   endtask

   task automatic write_byte(input logic [7:0] d, input bit expect_sent);
      @(negedge CLK_i);
      WR_i    = 1'b1;
      WDATA_i = d;
      if (expect_sent) exp_q.push_back(d);
      @(posedge CLK_i);
      #1;
      WR_i = 1'b0;
   endtask

   task automatic drain(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge CLK_i);
         if (exp_q.size() == 0 && EMPTY_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (20) @(negedge CLK_i);
   endtask

   task automatic test_reset();
      #1 RSTn_i = 1'b0;
      #1;
      n_checks++;
      if (COUNT_o !== 5'd0 || EMPTY_o !== 1'b1 || FULL_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_fifo: count=%0d empty=%b full=%b required 0/1/0", COUNT_o, EMPTY_o, FULL_o);
      end
      n_checks++;
      if (TX_START_o !== 1'b0 || TX_BYTE_o !== 8'h00 || OVF_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tx: start=%b byte=%02h ovf=%b required 0/00/0", TX_START_o, TX_BYTE_o, OVF_o);
      end
      repeat (2) @(negedge CLK_i);
      RSTn_i = 1'b1;
   endtask

   task automatic test_first_byte();
      apply_reset();
      write_byte(8'h41, 1'b1);
      n_checks++;
      if (COUNT_o !== 5'd1 || EMPTY_o !== 1'b0 || TX_START_o !== 1'b0) begin
         n_fail++;
         $display("FAIL first_after_write: count=%0d empty=%b start=%b required 1/0/0", COUNT_o, EMPTY_o, TX_START_o);
      end
      @(posedge CLK_i);
      #1;
      n_checks++;
      if (TX_START_o !== 1'b1 || TX_BYTE_o !== 8'h41) begin
         n_fail++;
         $display("FAIL first_launch: start=%b byte=%02h required 1/41", TX_START_o, TX_BYTE_o);
      end
      n_checks++;
      if (EMPTY_o !== 1'b1 || COUNT_o !== 5'd0) begin
         n_fail++;
         $display("FAIL first_popped: empty=%b count=%0d required 1/0", EMPTY_o, COUNT_o);
      end
      @(posedge CLK_i);
      #1;
      n_checks++;
      if (TX_START_o !== 1'b0 || TX_BYTE_o !== 8'h41) begin
         n_fail++;
         $display("FAIL first_pulse_width: start=%b byte=%02h required 0/41", TX_START_o, TX_BYTE_o);
      end
      repeat (10) @(negedge CLK_i);
   endtask

   task automatic test_stream();
      int p0;
      bit ok;
      apply_reset();
      model_en = 1'b1;
      busy_len = 10;
      p0 = pulse_cnt;
      for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
      drain(400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL stream_drain_timeout: left=%0d required 0", exp_q.size());
      end
      n_checks++;
      if (pulse_cnt - p0 != 16) begin
         n_fail++;
         $display("FAIL stream_pulses: got %0d required 16", pulse_cnt - p0);
      end
      n_checks++;
      if (COUNT_o !== 5'd0) begin
         n_fail++;
         $display("FAIL stream_count_end: got %0d required 0", COUNT_o);
      end
   endtask

   task automatic test_full_overflow();
      int p0;
      bit ok;
      apply_reset();
      force_busy = 1'b1;
      p0 = pulse_cnt;
      for (int i = 0; i < 17; i++) write_byte(8'h80 + 8'(i), i < 16);
      n_checks++;
      if (FULL_o !== 1'b1 || COUNT_o !== 5'd16) begin
         n_fail++;
         $display("FAIL full_flags: full=%b count=%0d required 1/16", FULL_o, COUNT_o);
      end
      n_checks++;
      if (OVF_o !== OVF_EXP) begin
         n_fail++;
         $display("FAIL ovf_set: got %b required %b", OVF_o, OVF_EXP);
      end
      @(negedge CLK_i);
      OVF_CLR_i = 1'b1;
      @(posedge CLK_i);
      #1;
      OVF_CLR_i = 1'b0;
      n_checks++;
      if (OVF_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b required 0", OVF_o);
      end
      @(negedge CLK_i);
      OVF_CLR_i = 1'b1;
      WR_i      = 1'b1;
      WDATA_i   = 8'h99;
      @(posedge CLK_i);
      #1;
      OVF_CLR_i = 1'b0;
      WR_i      = 1'b0;
      n_checks++;
      if (OVF_o !== OVF_EXP || COUNT_o !== 5'd16) begin
         n_fail++;
         $display("FAIL ovf_set_wins: ovf=%b count=%0d required %b/16", OVF_o, COUNT_o, OVF_EXP);
      end
      model_en   = 1'b1;
      busy_len   = 3;
      force_busy = 1'b0;
      drain(300, ok);
      n_checks++;
      if (!ok || pulse_cnt - p0 != 16) begin
         n_fail++;
         $display("FAIL full_drain: ok=%b pulses=%0d required 1/16", ok, pulse_cnt - p0);
      end
   endtask

   task automatic test_watchdog();
      int p0, c1;
      bit got;
      apply_reset();
      p0 = pulse_cnt;
      write_byte(8'h5A, 1'b1);
      write_byte(8'hA5, 1'b1);
      got = 1'b0;
      c1  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK_i);
         if (pulse_cnt - p0 == 1 && c1 == 0) c1 = last_pulse_cyc;
         if (pulse_cnt - p0 >= 2) begin
            got = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL watchdog_relaunch: pulses=%0d required 2", pulse_cnt - p0);
      end else begin
         n_checks++;
         if (last_pulse_cyc - c1 != 6) begin
            n_fail++;
            $display("FAIL watchdog_spacing: got %0d cycles required 6", last_pulse_cyc - c1);
         end
      end
      repeat (10) @(negedge CLK_i);
   endtask

   task automatic test_reset_mid_tx();
      int p0;
      apply_reset();
      model_en = 1'b1;
      busy_len = 10;
      for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i), 1'b1);
      n_checks++;
      if (COUNT_o !== 5'd5 || TX_BUSY_i !== 1'b1) begin
         n_fail++;
         $display("FAIL midtx_setup: count=%0d busy=%b required 5/1", COUNT_o, TX_BUSY_i);
      end
      #2;
      RSTn_i = 1'b0;
      exp_q.delete();
      #1;
      n_checks++;
      if (COUNT_o !== 5'd0 || TX_START_o !== 1'b0 || EMPTY_o !== 1'b1 || TX_BYTE_o !== 8'h00) begin
         n_fail++;
         $display("FAIL midtx_async_reset: count=%0d start=%b empty=%b byte=%02h required 0/0/1/00",
                  COUNT_o, TX_START_o, EMPTY_o, TX_BYTE_o);
      end
      repeat (2) @(negedge CLK_i);
      RSTn_i = 1'b1;
      p0 = pulse_cnt;
      repeat (30) @(negedge CLK_i);
      n_checks++;
      if (pulse_cnt != p0) begin
         n_fail++;
         $display("FAIL midtx_no_pulse: got %0d pulses required 0", pulse_cnt - p0);
      end
   endtask

   task automatic test_full_write_pop();
      int p0;
      bit ok;
      apply_reset();
      force_busy = 1'b1;
      p0 = pulse_cnt;
      for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i), 1'b1);
      @(negedge CLK_i);
      force_busy = 1'b0;
      model_en   = 1'b1;
      busy_len   = 3;
      WR_i       = 1'b1;
      WDATA_i    = 8'hEE;
      @(posedge CLK_i);
      #1;
      WR_i = 1'b0;
      n_checks++;
      if (COUNT_o !== 5'(DEPTH - 1) || FULL_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_wr_pop: count=%0d full=%b required %0d/0", COUNT_o, FULL_o, DEPTH - 1);
      end
      n_checks++;
      if (OVF_o !== OVF_EXP) begin
         n_fail++;
         $display("FAIL full_wr_pop_ovf: got %b required %b", OVF_o, OVF_EXP);
      end
      drain(300, ok);
      n_checks++;
      if (!ok || pulse_cnt - p0 != 16) begin
         n_fail++;
         $display("FAIL full_wr_pop_drain: ok=%b pulses=%0d required 1/16", ok, pulse_cnt - p0);
      end
   endtask

   initial begin
      RSTn_i     = 1'b1;
      WR_i       = 1'b0;
      WDATA_i    = 8'h00;
      OVF_CLR_i  = 1'b0;
      force_busy = 1'b0;
      model_en   = 1'b0;
      busy_len   = 0;
      prev_start = 1'b0;
      test_reset();
      test_first_byte();
      test_stream();
      test_full_overflow();
      test_watchdog();
      test_reset_mid_tx();
      test_full_write_pop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; a power of two from 2 to 256.
REQ-002 SHALL have parameter BUSY_WAIT, default 4, the maximum number of cycles spent waiting for TX_BUSY_i to rise.
REQ-003 SHALL have port CLK_i  in  1  single clock; every flop is rising-edge.
REQ-004 SHALL have port RSTn_i  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port WR_i  in  1  write strobe, one byte per high cycle.
REQ-006 SHALL have port WDATA_i  in  8  byte to enqueue.
REQ-007 SHALL have port FULL_o  out  1  high when count equals DEPTH.
REQ-008 SHALL have port EMPTY_o  out  1  high when count is 0.
REQ-009 SHALL have port COUNT_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port TX_BUSY_i  in  1  UART transmitter busy flag.
REQ-011 SHALL have port TX_START_o  out  1  one-cycle transmit-start pulse to the UART.
REQ-012 SHALL have port TX_BYTE_o  out  8  byte being sent; stable from the start pulse until the transmission completes.
REQ-013 SHALL have port OVF_CLR_i  in  1  clears the overflow flag.
REQ-014 SHALL have port OVF_o  out  1  sticky overflow flag.

Function
REQ-015 SHALL accept a write when WR_i=1 and FULL_o=0 at the clock edge; COUNT_o and EMPTY_o update after that same edge.
REQ-016 SHALL silently drop a write when FULL_o=1 at the edge, even if a pop occurs on the same edge.
REQ-017 SHALL, on a simultaneous accepted write and pop, leave COUNT_o unchanged while storage stays correct.
REQ-018 SHALL wrap read and write pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-019 SHALL run a state machine with states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE; all outputs are registered.
REQ-020 SHALL move IDLE -> LAUNCH on the edge where EMPTY_o=0 and TX_BUSY_i=0, loading TX_BYTE_o from the FIFO head and popping it on that edge.
REQ-021 SHALL assert TX_START_o for exactly the one cycle spent in LAUNCH, then move unconditionally to WAIT_BUSY.
REQ-022 SHALL move WAIT_BUSY -> WAIT_DONE when TX_BUSY_i=1.
REQ-023 SHALL move WAIT_BUSY -> IDLE after BUSY_WAIT cycles without TX_BUSY_i=1 (watchdog); the popped byte is considered sent.
REQ-024 SHALL move WAIT_DONE -> IDLE when TX_BUSY_i=0.
REQ-025 SHALL give a latency of 1 cycle from an accepted write into an empty FIFO in IDLE to TX_START_o=1 (write at edge n, pulse during cycle n+1).
REQ-026 SHALL never assert TX_START_o while TX_BUSY_i=1, and SHALL never issue back-to-back pulses.
REQ-027 SHALL allow writes during any state, including while a byte is in flight.

Reset
REQ-028 SHALL, while RSTn_i=0, force state IDLE, pointers and count to 0, EMPTY_o=1, FULL_o=0, TX_START_o=0, TX_BYTE_o=8'h00 and OVF_o=0, regardless of the clock.
REQ-029 SHALL discard FIFO contents and any in-flight tracking when reset is asserted mid-transmission; the storage array itself need not be reset.

Configuration
REQ-030 SHALL, with UART_TX_FIFO_OVF_EN defined, set OVF_o on any dropped write and clear it on OVF_CLR_i=1; when set and clear occur together, set wins.
REQ-031 SHALL, without UART_TX_FIFO_OVF_EN, keep both ports, tie OVF_o to 0, ignore OVF_CLR_i and add no overflow logic.

Structure
REQ-032 SHALL take the byte typedef and the tx-FSM state enum from the shared package uart_pkg.
REQ-033 SHALL place the storage array in sub-module uart_fifo_mem: synchronous write, combinational read of the head entry.

Verification
REQ-034 SHALL cover: reset, then write 8'h41 at edge n -> TX_START_o=1 during cycle n+1 with TX_BYTE_o=8'h41, and EMPTY_o=1 after edge n+1.
REQ-035 SHALL cover: 16 writes 8'h00..8'h0F with a busy model of 10 cycles per byte -> 16 pulses in order, none while busy, COUNT_o ends at 0.
REQ-036 SHALL cover: DEPTH=16 with busy held high, 17 writes -> FULL_o=1, 17th byte absent from the output, OVF_o=1 (macro on) or 0 (macro off).
REQ-037 SHALL cover: TX_BUSY_i never rises after a pulse -> return to IDLE after 4 cycles, and the next byte is launched.
REQ-038 SHALL cover: RSTn_i low mid-WAIT_DONE with 5 bytes queued -> COUNT_o=0 and TX_START_o=0 immediately (asynchronously), with no pulse after release.
REQ-039 SHALL cover: full FIFO, write and pop on the same edge -> write dropped, COUNT_o=DEPTH-1.
